// File: rtl/hilo_seq_pkg.sv
// Shared types and constants for the HI/LO multicycle sequencer.
package hilo_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        WRITE,
        EXC
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int DEF_DIV_CYCLES  = 32;
    localparam int DEF_MULT_CYCLES = 32;
    localparam int DEF_CNT_W       = 6;

endpackage

// File: rtl/hilo_seq_if.sv
// Control-unit <-> HI/LO sequencer signal bundle; master is the requester side.
interface hilo_seq_if;
    import hilo_seq_pkg::*;

    logic start;
    logic op;
    logic hilo_rd;
    logic div_zero_n;
    logic div_init;
    logic mult_init;
    logic hilo_sel;
    logic hilo_we;
    logic busy;
    logic stall;
    logic done;
    logic div_zero_exc;
    logic illegal_op;

    modport master (
        output start, op, hilo_rd, div_zero_n,
        input  div_init, mult_init, hilo_sel, hilo_we, busy, stall, done,
               div_zero_exc, illegal_op
    );

    modport slave (
        input  start, op, hilo_rd, div_zero_n,
        output div_init, mult_init, hilo_sel, hilo_we, busy, stall, done,
               div_zero_exc, illegal_op
    );

endinterface

// File: rtl/hilo_seq_cycle_counter.sv
// Clear/enable iteration counter with terminal-count flag against a runtime limit.
module seq_cycle_counter
    import hilo_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

    assign tc = (cnt == limit);

endmodule

// File: rtl/hilo_seq.sv
// HI/LO multicycle sequencer: init pulse, iteration count, single HI/LO write or div-by-zero exception.
// Define HILO_SEQ_MULT_EN to sequence MULT requests; otherwise they are dropped with illegal_op.
module hilo_seq
    import hilo_seq_pkg::*;
#(
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      reset,
    hilo_seq_if.slave bus
);

    state_t           state, state_nxt;
    logic             accept, drop, sel, illegal_q;
    logic [CNT_W-1:0] cnt, limit;
    logic             tc;
    logic             div_init_c, mult_init_c, we_c, done_c, exc_c;

`ifdef HILO_SEQ_MULT_EN
    logic op_q;

    assign accept = (state == IDLE) & bus.start;
    assign drop   = 1'b0;

    always_ff @(posedge clk) begin
        if (reset)
            op_q <= OP_MULT;
        else if (accept)
            op_q <= bus.op;
    end

    assign sel = op_q;
`else
    assign accept = (state == IDLE) & bus.start & (bus.op == OP_DIV);
    assign drop   = (state == IDLE) & bus.start & (bus.op == OP_MULT);
    assign sel    = OP_DIV;
`endif

    // Iteration budget follows the latched unit; the limit is the last RUN count value.
    assign limit = (sel == OP_DIV) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

    seq_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state != RUN),
        .en    (state == RUN),
        .limit (limit),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            illegal_q <= drop;
        end
    end

    always_comb begin
        state_nxt   = state;
        div_init_c  = 1'b0;
        mult_init_c = 1'b0;
        we_c        = 1'b0;
        done_c      = 1'b0;
        exc_c       = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = INIT;
            INIT: begin
                if (sel == OP_DIV) div_init_c  = 1'b1;
                else               mult_init_c = 1'b1;
                state_nxt = RUN;
            end
            // The divider's zero flag is only valid on the first RUN cycle.
            RUN: begin
                if ((sel == OP_DIV) && (cnt == '0) && !bus.div_zero_n)
                    state_nxt = EXC;
                else if (tc)
                    state_nxt = WRITE;
            end
            WRITE: begin
                we_c      = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            EXC: begin
                exc_c     = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.div_init     = div_init_c;
    assign bus.mult_init    = mult_init_c;
    assign bus.hilo_sel     = sel;
    assign bus.hilo_we      = we_c;
    assign bus.done         = done_c;
    assign bus.div_zero_exc = exc_c;
    assign bus.illegal_op   = illegal_q;
    assign bus.busy         = (state != IDLE);
    assign bus.stall        = (state != IDLE) & (bus.start | bus.hilo_rd);

endmodule
